// File: rtl/pipe_stall_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline stall/flush controller:
//     - ctrl_state_t : memory-wait FSM state encoding (IDLE, WAIT)
//     - M_DEF        : default register address width
//     - CW_DEF       : default stall performance counter width
//   Optional feature macro used by the controller: STALL_PERF_EN.
// ----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int M_DEF  = 4;
    localparam int CW_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl_if
//   Bundles the hazard inputs and the stall/flush outputs of the pipeline
//   sequencing controller.
//   Modports:
//     master : the controller (reads hazard inputs, drives stall/flush/mem_req)
//     slave  : the datapath side (drives hazard inputs, reads controls)
//   Signals:
//     memrd_M, memwr_M, mem_ready           memory-stage access and completion
//     regw_E, regmem_E, regScr_E            execute-stage writer / load info
//     srcA_D, srcB_D                        decode-stage source registers
//     mem_req                               data memory request
//     stall_F/D/E/M, flush_E, flush_W       pipeline register controls
//     busy, stall_cycles                    status and stall performance count
// ----------------------------------------------------------------------------
interface pipe_stall_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int CW = CW_DEF
);
    logic          memrd_M;
    logic          memwr_M;
    logic          mem_ready;
    logic          regw_E;
    logic          regmem_E;
    logic [M-1:0]  regScr_E;
    logic [M-1:0]  srcA_D;
    logic [M-1:0]  srcB_D;

    logic          mem_req;
    logic          stall_F;
    logic          stall_D;
    logic          stall_E;
    logic          stall_M;
    logic          flush_E;
    logic          flush_W;
    logic          busy;
    logic [CW-1:0] stall_cycles;

    modport master (
        input  memrd_M, memwr_M, mem_ready, regw_E, regmem_E,
               regScr_E, srcA_D, srcB_D,
        output mem_req, stall_F, stall_D, stall_E, stall_M,
               flush_E, flush_W, busy, stall_cycles
    );

    modport slave (
        output memrd_M, memwr_M, mem_ready, regw_E, regmem_E,
               regScr_E, srcA_D, srcB_D,
        input  mem_req, stall_F, stall_D, stall_E, stall_M,
               flush_E, flush_W, busy, stall_cycles
    );

endinterface

// File: rtl/pipe_stall_ctrl_stall_counter.sv
// ----------------------------------------------------------------------------
// stall_counter
//   Saturating CW-bit up-counter with enable; sticks at all-ones.
//   Only built when STALL_PERF_EN is defined.
//   Ports:
//     clk   in   clock
//     rst   in   asynchronous active-high reset, clears the count
//     en    in   count this cycle
//     count out  current count
// ----------------------------------------------------------------------------
`ifdef STALL_PERF_EN
module stall_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (en && (count_reg != {CW{1'b1}})) begin
            count_reg <= count_reg + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign count = count_reg;

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_stall_ctrl
//   Stall/flush sequencing for the 5-stage pipeline. Handles variable-latency
//   data memory accesses (req/ready) and execute->decode load-use hazards.
//   A memory stall freezes F/D/E/M and kills the instruction entering W;
//   a load-use hazard freezes F/D and bubbles E. Memory stalls win.
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset; forces every output to 0
//     bus  pipe_stall_ctrl_if.master (hazard inputs, stall/flush outputs)
//   Optional feature: STALL_PERF_EN builds a saturating stall-cycle counter;
//   without it stall_cycles is tied to 0.
// ----------------------------------------------------------------------------
module pipe_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int M  = M_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stall_ctrl_if.master bus
);

    ctrl_state_t state_reg;
    ctrl_state_t state_next;

    logic          mem_acc;
    logic          mem_req_c;
    logic          mem_stall;
    logic          load_use;
    logic          lu_stall;
    logic [1:0]    src_match;
    logic [M-1:0]  src_d [2];
    logic [CW-1:0] stall_cnt;

    // A simultaneous load+store flag pair is one access.
    assign mem_acc = bus.memrd_M | bus.memwr_M;

    // Decode source compare; register zero is deliberately not excluded.
    assign src_d[0] = bus.srcA_D;
    assign src_d[1] = bus.srcB_D;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign src_match[gi] = (bus.regScr_E == src_d[gi]);
        end
    endgenerate

    assign load_use = bus.regmem_E & bus.regw_E & (|src_match);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mem_req_c  = 1'b0;
        mem_stall  = 1'b0;
        case (state_reg)
            IDLE: begin
                mem_req_c = mem_acc;
                // A ready in the request cycle is a zero-wait access.
                mem_stall = mem_acc & ~bus.mem_ready;
                if (mem_stall) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                mem_req_c = 1'b1;
                // Release happens in the ready cycle itself.
                mem_stall = ~bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // While memory is stalled, E is held rather than bubbled; the
        // load-use check takes effect again once the stall releases.
        lu_stall = load_use & ~mem_stall;
    end

    // Combinational outputs are masked during reset so the abandoned
    // request drops immediately, not at the next edge.
    assign bus.mem_req = mem_req_c & ~rst;
    assign bus.stall_F = (mem_stall | lu_stall) & ~rst;
    assign bus.stall_D = (mem_stall | lu_stall) & ~rst;
    assign bus.stall_E = mem_stall & ~rst;
    assign bus.stall_M = mem_stall & ~rst;
    assign bus.flush_E = lu_stall & ~rst;
    assign bus.flush_W = mem_stall & ~rst;
    assign bus.busy    = (state_reg == WAIT);

`ifdef STALL_PERF_EN
    stall_counter #(
        .CW (CW)
    ) u_stall_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.stall_F),
        .count (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

    assign bus.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
module tb_pipe_stall_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int M  = M_DEF;
    localparam int CW = CW_DEF;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_stall_ctrl_if #(.M(M), .CW(CW)) bus ();

    pipe_stall_ctrl #(.M(M), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // vec bits: [7]mem_req [6]stall_F [5]stall_D [4]stall_E [3]stall_M
    //           [2]flush_E [1]flush_W [0]busy
    typedef struct {
        string         tag;
        logic [7:0]    vec;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb_q[$];
    int            total = 0;
    int            bad   = 0;
    logic [CW-1:0] perf_cnt = '0;

    function automatic logic [7:0] obs_vec();
        return {bus.mem_req, bus.stall_F, bus.stall_D, bus.stall_E,
                bus.stall_M, bus.flush_E, bus.flush_W, bus.busy};
    endfunction

    task automatic set_in(input logic rd, input logic wr, input logic rdy,
                          input logic rw, input logic rm,
                          input logic [M-1:0] rs, input logic [M-1:0] sa,
                          input logic [M-1:0] sb);
        bus.memrd_M   = rd;
        bus.memwr_M   = wr;
        bus.mem_ready = rdy;
        bus.regw_E    = rw;
        bus.regmem_E  = rm;
        bus.regScr_E  = rs;
        bus.srcA_D    = sa;
        bus.srcB_D    = sb;
    endtask

    // Expected counter value is the number of stall cycles seen before
    // this one; this cycle's stall is added afterwards.
    task automatic push_exp(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.vec = v;
        e.cnt = perf_cnt;
        sb_q.push_back(e);
`ifdef STALL_PERF_EN
        if (v[6] && (perf_cnt != {CW{1'b1}})) perf_cnt = perf_cnt + 1'b1;
`endif
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_empty observed=none expected=entry");
        end else begin
            e = sb_q.pop_front();
            total++;
            assert (obs_vec() === e.vec) else begin
                bad++;
                $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs_vec(), e.vec);
            end
            total++;
            assert (bus.stall_cycles === e.cnt) else begin
                bad++;
                $error("FAIL %s stall_cycles observed=%0d expected=%0d", e.tag, bus.stall_cycles, e.cnt);
            end
            $display("step %-10s ctrl=%b stall_cycles=%0d", e.tag, obs_vec(), bus.stall_cycles);
        end
    endtask

    task automatic step(input string tag, input logic rd, input logic wr,
                        input logic rdy, input logic rw, input logic rm,
                        input logic [M-1:0] rs, input logic [M-1:0] sa,
                        input logic [M-1:0] sb, input logic [7:0] v);
        @(negedge clk);
        set_in(rd, wr, rdy, rw, rm, rs, sa, sb);
        push_exp(tag, v);
        #2;
        check_pop();
    endtask

    initial begin
        // Reset with active hazard inputs: everything must read 0.
        rst = 1'b1;
        set_in(1, 1, 0, 1, 1, 5, 5, 5);
        #2;
        push_exp("rst_init", 8'b0000_0000);
        check_pop();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Zero-wait accesses and stray ready.
        step("ld_zw",    1, 0, 1, 0, 0, 0, 0, 0, 8'b1000_0000);
        step("ld_zw_nx", 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
        step("both_zw",  1, 1, 1, 0, 0, 0, 0, 0, 8'b1000_0000);
        step("rdy_idle", 0, 0, 1, 0, 0, 0, 0, 0, 8'b0000_0000);

        // Store with ready three cycles after the request.
        step("st_w1",    0, 1, 0, 0, 0, 0, 0, 0, 8'b1111_1010);
        step("st_w2",    0, 1, 0, 0, 0, 0, 0, 0, 8'b1111_1011);
        step("st_w3",    0, 1, 0, 0, 0, 0, 0, 0, 8'b1111_1011);
        step("st_rel",   0, 1, 1, 0, 0, 0, 0, 0, 8'b1000_0001);
        step("st_done",  0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);

        // Load-use hazards.
        step("lu_b",     0, 0, 0, 1, 1, 5, 0, 5, 8'b0110_0100);
        step("lu_miss",  0, 0, 0, 1, 1, 6, 0, 5, 8'b0000_0000);
        step("lu_a",     0, 0, 0, 1, 1, 3, 3, 9, 8'b0110_0100);
        step("lu_nrw",   0, 0, 0, 0, 1, 3, 3, 9, 8'b0000_0000);
        step("lu_nld",   0, 0, 0, 1, 0, 3, 3, 9, 8'b0000_0000);
        step("lu_r0",    0, 0, 0, 1, 1, 0, 0, 0, 8'b0110_0100);

        // Load-use concurrent with a two-cycle memory wait.
        step("cc_w1",    1, 0, 0, 1, 1, 5, 5, 0, 8'b1111_1010);
        step("cc_w2",    1, 0, 0, 1, 1, 5, 5, 0, 8'b1111_1011);
        step("cc_rel",   1, 0, 1, 1, 1, 5, 5, 0, 8'b1110_0101);
        step("cc_after", 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);

        // Reset in the middle of a wait.
        step("rst_w1",   1, 0, 0, 0, 0, 0, 0, 0, 8'b1111_1010);
        step("rst_w2",   1, 0, 0, 0, 0, 0, 0, 0, 8'b1111_1011);
        rst = 1'b1;
        #1;
        perf_cnt = '0;
        push_exp("rst_mid", 8'b0000_0000);
        check_pop();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst = 1'b0;
        step("rst_rel",  1, 0, 0, 0, 0, 0, 0, 0, 8'b1111_1010);
        step("rst_fin",  1, 0, 1, 0, 0, 0, 0, 0, 8'b1000_0001);
        step("rst_idle", 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);

`ifdef STALL_PERF_EN
        // Long wait to drive the counter into saturation.
        @(negedge clk);
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CW) + 10; i++) begin
            @(posedge clk);
        end
        perf_cnt = {CW{1'b1}};
        step("sat_wait", 1, 0, 0, 0, 0, 0, 0, 0, 8'b1111_1011);
        step("sat_rel",  1, 0, 1, 0, 0, 0, 0, 0, 8'b1000_0001);
        step("sat_idle", 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
